// File: rtl/rom_ahb_ws_pkg.sv
// rom_ahb_ws_pkg: shared configuration, AHB transfer constants and ROM image helper

package config_pkg;
    localparam int XLEN    = 64;
    localparam int PA_BITS = 32;
endpackage

package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
endpackage

package rom_ahb_ws_pkg;
    import config_pkg::*;

    // wide enough for the largest legal wait-state count (15)
    localparam int WS_W = 4;

    // Preloaded ROM image: word idx holds {C0DE_0000 | idx, ~idx}
    function automatic logic [XLEN-1:0] rom_image_word(input logic [31:0] idx);
        return XLEN'({32'hC0DE_0000 | idx, ~idx});
    endfunction
endpackage

// File: rtl/rom_ahb_ws_if.sv
// rom_ahb_ws_if: AHB-lite slave-side signal bundle for the ROM

interface rom_ahb_ws_if;
    import config_pkg::*;

    logic               HSELRom;
    logic [PA_BITS-1:0] HADDR;
    logic               HWRITE;
    logic               HREADY;
    logic [1:0]         HTRANS;
    logic [XLEN-1:0]    HREADRom;
    logic               HRESPRom;
    logic               HREADYRom;

    modport master (
        output HSELRom, HADDR, HWRITE, HREADY, HTRANS,
        input  HREADRom, HRESPRom, HREADYRom
    );

    modport slave (
        input  HSELRom, HADDR, HWRITE, HREADY, HTRANS,
        output HREADRom, HRESPRom, HREADYRom
    );
endinterface

// File: rtl/rom_ahb_ws_rom1p1r.sv
// rom1p1r: single-port ROM with registered output that holds while ce is low

module rom1p1r
    import rom_ahb_ws_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 64,
    parameter int PRELOAD    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_ce,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_q
);
    logic [DATA_WIDTH-1:0] r_q;

    // read the addressed word only on ce, otherwise keep the last word
    always_ff @(posedge i_clk) begin
        if (i_ce)
            r_q <= (PRELOAD != 0) ? DATA_WIDTH'(rom_image_word(32'(i_addr))) : '0;
    end

    assign o_q = r_q;
endmodule

// File: rtl/rom_ahb_ws.sv
// rom_ahb_ws: AHB-lite ROM slave with programmable read wait states and error responses

module rom_ahb_ws
    import config_pkg::*;
    import ahb_pkg::*;
    import rom_ahb_ws_pkg::*;
#(
    parameter int RANGE        = 65535,
    parameter int PRELOAD      = 0,
    parameter int WAIT_STATES  = 0,
    parameter int ERR_ON_WRITE = 1
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    rom_ahb_ws_if.slave  bus
);
    localparam int OFFSET     = $clog2(XLEN / 8);
    localparam int ADDR_WIDTH = $clog2(RANGE / 8);

    typedef enum logic [1:0] {READY, WAIT, ERR1, ERR2} state_t;

    state_t          r_state, w_state_nxt;
    logic [WS_W-1:0] r_cnt, w_cnt_nxt;
    logic            w_accept, w_in_range, w_err, w_read;
    logic            w_hready, w_hresp;

    // only READY and ERR2 can take a new address phase
    assign w_accept   = bus.HSELRom & bus.HREADY
                      & ((bus.HTRANS == HTRANS_NONSEQ) | (bus.HTRANS == HTRANS_SEQ))
                      & ((r_state == READY) | (r_state == ERR2));
    assign w_in_range = bus.HADDR <= PA_BITS'(RANGE);
    assign w_err      = w_accept & (~w_in_range | (bus.HWRITE & (ERR_ON_WRITE != 0)));
    assign w_read     = w_accept & w_in_range & ~bus.HWRITE;

    // state and wait counter, cleared asynchronously
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next state, wait countdown and response outputs
    always_comb begin
        w_state_nxt = READY;
        w_cnt_nxt   = r_cnt;
        w_hready    = 1'b1;
        w_hresp     = 1'b0;
        case (r_state)
            READY, ERR2: begin
                w_hresp     = (r_state == ERR2);
                w_state_nxt = w_err ? ERR1 : (w_read && WAIT_STATES > 0) ? WAIT : READY;
                w_cnt_nxt   = w_read ? WS_W'(WAIT_STATES) : '0;
            end
            WAIT: begin
                w_hready    = 1'b0;
                w_cnt_nxt   = r_cnt - WS_W'(1);
                w_state_nxt = (r_cnt == WS_W'(1)) ? READY : WAIT;
            end
            ERR1: begin
                w_hready    = 1'b0;
                w_hresp     = 1'b1;
                w_state_nxt = ERR2;
            end
            default: w_state_nxt = READY;
        endcase
    end

    assign bus.HREADYRom = w_hready;
    assign bus.HRESPRom  = w_hresp;

    rom1p1r #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (XLEN),
        .PRELOAD    (PRELOAD)
    ) u_rom (
        .i_clk  (HCLK),
        .i_ce   (w_read),
        .i_addr (bus.HADDR[ADDR_WIDTH+OFFSET-1:OFFSET]),
        .o_q    (bus.HREADRom)
    );
endmodule

// File: tb/tb_rom_ahb_ws.sv
// tb_rom_ahb_ws: vector table, corner sequences and random traffic on two ROM configurations

module tb_rom_ahb_ws;
    import ahb_pkg::*;

    typedef struct {
        int          d;
        bit          s;
        logic [1:0]  t;
        bit          w;
        logic [31:0] a;
        int          low;
        bit          err;
        bit          rd;
    } vec_t;

    logic        clk, rst_n;
    logic        sel[2], wr[2];
    logic [1:0]  trans[2];
    logic [31:0] addr[2];
    logic        rdy[2], resp[2];
    logic [63:0] rdata[2];
    logic [63:0] lw[2];
    bit          lv[2];
    int          n_cmp, n_err;
    vec_t        tbl[$];

    rom_ahb_ws_if bus0();
    rom_ahb_ws_if bus1();

    assign bus0.HSELRom = sel[0];
    assign bus0.HADDR   = addr[0];
    assign bus0.HWRITE  = wr[0];
    assign bus0.HTRANS  = trans[0];
    assign bus0.HREADY  = bus0.HREADYRom;
    assign rdy[0]       = bus0.HREADYRom;
    assign resp[0]      = bus0.HRESPRom;
    assign rdata[0]     = bus0.HREADRom;

    assign bus1.HSELRom = sel[1];
    assign bus1.HADDR   = addr[1];
    assign bus1.HWRITE  = wr[1];
    assign bus1.HTRANS  = trans[1];
    assign bus1.HREADY  = bus1.HREADYRom;
    assign rdy[1]       = bus1.HREADYRom;
    assign resp[1]      = bus1.HRESPRom;
    assign rdata[1]     = bus1.HREADRom;

    rom_ahb_ws #(.RANGE(65535), .PRELOAD(1), .WAIT_STATES(0), .ERR_ON_WRITE(1)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus0)
    );
    rom_ahb_ws #(.RANGE(65535), .PRELOAD(1), .WAIT_STATES(3), .ERR_ON_WRITE(0)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // expected preloaded word for a byte address
    function automatic logic [63:0] exp_word(logic [31:0] byte_addr);
        logic [31:0] i;
        i = byte_addr >> 3;
        return {32'hC0DE_0000 + i, 32'hFFFF_FFFF - i};
    endfunction

    function automatic vec_t v(int d, bit s, logic [1:0] t, bit w, logic [31:0] a, int low, bit err, bit rd);
        vec_t x;
        x.d = d; x.s = s; x.t = t; x.w = w; x.a = a; x.low = low; x.err = err; x.rd = rd;
        return x;
    endfunction

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h want %h", nm, d, act, exp);
        end
    endtask

    // one transfer: address phase now (at a negedge), then check every data-phase cycle
    task automatic xfer(int d, bit s, logic [1:0] t, bit w, logic [31:0] a, int low, bit err, bit rd);
        sel[1-d] = 1'b0;
        sel[d] = s; trans[d] = t; wr[d] = w; addr[d] = a;
        if (rd) begin
            lw[d] = exp_word(a);
            lv[d] = 1'b1;
        end
        @(posedge clk);
        for (int j = 0; j <= low; j++) begin
            @(negedge clk);
            chk("hready", d, 64'(rdy[d]), 64'(j == low));
            chk("hresp", d, 64'(resp[d]), 64'(err));
            if (lv[d]) chk("hrdata", d, rdata[d], lw[d]);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        lv[0] = 1'b0; lv[1] = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sel[d] = 1'b0; wr[d] = 1'b0; trans[d] = HTRANS_IDLE; addr[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_hready", d, 64'(rdy[d]), 64'd1);
            chk("reset_hresp", d, 64'(resp[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        tbl.push_back(v(0, 1, HTRANS_NONSEQ, 0, 32'h0,     0, 0, 1));
        tbl.push_back(v(0, 1, HTRANS_SEQ,    0, 32'h8,     0, 0, 1));
        tbl.push_back(v(0, 1, HTRANS_SEQ,    0, 32'h10,    0, 0, 1));
        tbl.push_back(v(0, 1, HTRANS_NONSEQ, 1, 32'h20,    1, 1, 0));
        tbl.push_back(v(0, 1, HTRANS_NONSEQ, 0, 32'h20,    0, 0, 1));
        tbl.push_back(v(0, 1, HTRANS_NONSEQ, 0, 32'h10000, 1, 1, 0));
        tbl.push_back(v(0, 1, HTRANS_NONSEQ, 0, 32'h28,    0, 0, 1));
        tbl.push_back(v(0, 1, HTRANS_BUSY,   0, 32'h30,    0, 0, 0));
        tbl.push_back(v(0, 1, HTRANS_IDLE,   0, 32'h38,    0, 0, 0));
        tbl.push_back(v(0, 0, HTRANS_NONSEQ, 0, 32'h40,    0, 0, 0));
        tbl.push_back(v(0, 1, HTRANS_NONSEQ, 0, 32'hFFFF,  0, 0, 1));
        tbl.push_back(v(0, 1, HTRANS_NONSEQ, 1, 32'h10008, 1, 1, 0));
        tbl.push_back(v(1, 1, HTRANS_NONSEQ, 0, 32'h18,    3, 0, 1));
        tbl.push_back(v(1, 1, HTRANS_NONSEQ, 1, 32'h20,    0, 0, 0));
        tbl.push_back(v(1, 1, HTRANS_NONSEQ, 0, 32'h20,    3, 0, 1));
        tbl.push_back(v(1, 1, HTRANS_NONSEQ, 1, 32'h10000, 1, 1, 0));
        tbl.push_back(v(1, 1, HTRANS_NONSEQ, 0, 32'h8,     3, 0, 1));
        tbl.push_back(v(1, 1, HTRANS_BUSY,   0, 32'h0,     0, 0, 0));
        tbl.push_back(v(1, 1, HTRANS_SEQ,    0, 32'hFFF8,  3, 0, 1));
        tbl.push_back(v(1, 0, HTRANS_IDLE,   0, 32'h0,     0, 0, 0));
        foreach (tbl[i])
            xfer(tbl[i].d, tbl[i].s, tbl[i].t, tbl[i].w, tbl[i].a, tbl[i].low, tbl[i].err, tbl[i].rd);

        // reset on the second wait cycle of a read
        sel[0] = 1'b0;
        sel[1] = 1'b1; trans[1] = HTRANS_NONSEQ; wr[1] = 1'b0; addr[1] = 32'h18;
        lw[1] = exp_word(32'h18); lv[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wait1_hready", 1, 64'(rdy[1]), 64'd0);
        @(negedge clk);
        chk("wait2_hready", 1, 64'(rdy[1]), 64'd0);
        rst_n = 1'b0; sel[1] = 1'b0; trans[1] = HTRANS_IDLE;
        #1;
        chk("rst_wait_hready", 1, 64'(rdy[1]), 64'd1);
        chk("rst_wait_hresp", 1, 64'(resp[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1, HTRANS_NONSEQ, 0, 32'h8, 3, 0, 1);

        // reset during the first error cycle
        sel[1] = 1'b0;
        sel[0] = 1'b1; trans[0] = HTRANS_NONSEQ; wr[0] = 1'b0; addr[0] = 32'h10000;
        @(posedge clk);
        @(negedge clk);
        chk("err1_hresp", 0, 64'(resp[0]), 64'd1);
        rst_n = 1'b0; sel[0] = 1'b0; trans[0] = HTRANS_IDLE;
        #1;
        chk("rst_err_hready", 0, 64'(rdy[0]), 64'd1);
        chk("rst_err_hresp", 0, 64'(resp[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_hresp", 0, 64'(resp[0]), 64'd0);
        xfer(0, 1, HTRANS_NONSEQ, 0, 32'h38, 0, 0, 1);

        // random traffic against a transaction-level response model
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 200; k++) begin
                bit          s, w, err, rd;
                logic [1:0]  t;
                logic [31:0] a;
                int          low;
                s = $urandom_range(0, 7) != 0;
                t = 2'($urandom_range(0, 3));
                w = $urandom_range(0, 3) == 0;
                a = ($urandom_range(0, 7) == 0) ? 32'h10000 + $urandom_range(0, 4095) : $urandom_range(0, 65535);
                low = 0; err = 1'b0; rd = 1'b0;
                if (s && (t == HTRANS_NONSEQ || t == HTRANS_SEQ)) begin
                    if (a > 32'd65535 || (w && d == 0)) begin
                        low = 1; err = 1'b1;
                    end else if (!w) begin
                        low = (d == 0) ? 0 : 3; rd = 1'b1;
                    end
                end
                xfer(d, s, t, w, a, low, err, rd);
            end
            xfer(d, 0, HTRANS_IDLE, 0, 32'h0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
